mcu_pin_input_debounce: RTL and testbench

// - Upstream feeder of the MCU<->FPGA register bus: conditions 128 raw FPGA input pins

---
 rtl/mcu_pin_input_debounce.sv | 142 ++++++++++++++
 tb/tb_mcu_pin_input_debounce.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_pin_input_debounce.sv
// ---------------------------------------------------------------------------
// mcu_pin_input_debounce
//
// Conditions the raw FPGA input pins into the banked, debounced pin-state
// array that the MCU register bus returns on reads. Each pin passes through a
// 2-FF synchronizer and then a counter-based debouncer that advances only on
// a shared prescaled sample tick.
//
// Optional feature macro: PIN_CHANGE_IRQ_EN
//   When defined, sticky per-bank change flags and an MCU attention line are
//   added. When undefined, those ports and their logic do not exist.
//
// Ports:
//   CLK50             in   system clock (50 MHz)
//   RST               in   synchronous, active-high reset
//   pins_raw          in   asynchronous pins; bit b*BANK_W+i is bank b, bit i
//   bypass            in   1: skip debouncing, state follows synchronizer
//   input_pins_state  out  [0:NUM_BANKS-1][BANK_W] registered pin state
//   change_mask       out  (PIN_CHANGE_IRQ_EN) sticky per-bank change flags
//   irq_clear         in   (PIN_CHANGE_IRQ_EN) per-bank clear strobes
//   pin_irq           out  (PIN_CHANGE_IRQ_EN) registered OR of change_mask
// ---------------------------------------------------------------------------
module mcu_pin_input_debounce #(
  parameter int NUM_BANKS    = 16,
  parameter int BANK_W       = 8,
  parameter int PRESCALE     = 500,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                                CLK50,
  input  logic                                RST,
  input  logic [NUM_BANKS*BANK_W-1:0]         pins_raw,
  input  logic                                bypass,
  output logic [0:NUM_BANKS-1][BANK_W-1:0]    input_pins_state
`ifdef PIN_CHANGE_IRQ_EN
  ,
  output logic [NUM_BANKS-1:0]                change_mask,
  input  logic [NUM_BANKS-1:0]                irq_clear,
  output logic                                pin_irq
`endif
);

  localparam int NUM_PINS = NUM_BANKS * BANK_W;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W    = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [NUM_PINS-1:0]             sync1;
  logic [NUM_PINS-1:0]             sync2;
  logic [NUM_PINS-1:0]             state;
  logic [NUM_PINS-1:0]             state_next;
  logic [NUM_PINS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_PINS-1:0][CNT_W-1:0]  cnt_next;
  logic [PRE_W-1:0]                pre_cnt;
  logic                            tick;

  // Shared sample tick. With PRESCALE=1 the counter stays at 0 and the tick
  // is asserted on every cycle. The prescaler keeps running during bypass.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge CLK50) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Debounce decision per pin. A sample that matches the current state
  // discards any partial count, so bounces shorter than DEBOUNCE_CNT samples
  // never reach the output. The counter stops at CNT_LAST and cannot wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (bypass) begin
      state_next = sync2;
      cnt_next   = '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync2[i] == state[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          state_next[i] = sync2[i];
          cnt_next[i]   = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // The synchronizer runs in every mode, including bypass, so leaving bypass
  // resumes debouncing from an up-to-date sample.
  always_ff @(posedge CLK50) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= pins_raw;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Bank 0 sits at the left of the ascending packed output array; each bank
  // keeps its bit order from pins_raw.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign input_pins_state[b] = state[b*BANK_W +: BANK_W];
  end

`ifdef PIN_CHANGE_IRQ_EN
  logic [NUM_BANKS-1:0] bank_changed;

  // A bank is flagged in the same cycle its state register is updated,
  // whether the update came from the debouncer or from bypass.
  always_comb begin
    bank_changed = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_changed[b] = |(state_next[b*BANK_W +: BANK_W] ^ state[b*BANK_W +: BANK_W]);
    end
  end

  // Setting takes precedence over a coincident clear so a change arriving
  // with an acknowledge is never lost.
  always_ff @(posedge CLK50) begin
    if (RST) begin
      change_mask <= '0;
      pin_irq     <= 1'b0;
    end else begin
      change_mask <= (change_mask & ~irq_clear) | bank_changed;
      pin_irq     <= |change_mask;
    end
  end
`endif

endmodule

// File: tb/tb_mcu_pin_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_mcu_pin_input_debounce
//
// Directed bench for mcu_pin_input_debounce with PRESCALE=4, DEBOUNCE_CNT=3.
// Expected values are queued with the clock edge at which they must hold and
// are compared when that edge has passed. IRQ checks are only built when
// PIN_CHANGE_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module tb_mcu_pin_input_debounce;

  localparam int NUM_BANKS    = 16;
  localparam int BANK_W       = 8;
  localparam int NUM_PINS     = NUM_BANKS * BANK_W;
  localparam int PRESCALE     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             bypass;
  logic [NUM_PINS-1:0]              pins_raw;
  logic [0:NUM_BANKS-1][BANK_W-1:0] input_pins_state;
`ifdef PIN_CHANGE_IRQ_EN
  logic [NUM_BANKS-1:0]             change_mask;
  logic [NUM_BANKS-1:0]             irq_clear;
  logic                             pin_irq;
`endif

  mcu_pin_input_debounce #(
    .NUM_BANKS   (NUM_BANKS),
    .BANK_W      (BANK_W),
    .PRESCALE    (PRESCALE),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .CLK50           (clk),
    .RST             (rst),
    .pins_raw        (pins_raw),
    .bypass          (bypass),
    .input_pins_state(input_pins_state)
`ifdef PIN_CHANGE_IRQ_EN
    ,
    .change_mask     (change_mask),
    .irq_clear       (irq_clear),
    .pin_irq         (pin_irq)
`endif
  );

  always #5 clk = ~clk;

  // kind 0: input_pins_state, kind 1: change_mask, kind 2: pin_irq
  typedef struct {
    int           due;
    int           kind;
    logic [127:0] val;
    string        tag;
  } sb_entry_t;

  sb_entry_t                        sb_q[$];
  int                               edge_n   = 0;
  int                               last_rst = 0;
  int                               n_checks = 0;
  int                               n_fail   = 0;
  logic [0:NUM_BANKS-1][BANK_W-1:0] exp_banks;
  logic [NUM_PINS-1:0]              raw_q;

  task automatic push_check(input int due, input int kind, input logic [127:0] val,
                            input string tag);
    sb_entry_t e;
    int        idx;
    bit        found;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    idx    = sb_q.size();
    found  = 1'b0;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (!found && sb_q[i].due > due) begin
        idx   = i;
        found = 1'b1;
      end
    end
    sb_q.insert(idx, e);
  endtask

  task automatic checkOutput(input sb_entry_t e);
    logic [127:0] obs;
    obs = '0;
    case (e.kind)
      0: obs = input_pins_state;
`ifdef PIN_CHANGE_IRQ_EN
      1: obs = {112'b0, change_mask};
      2: obs = {127'b0, pin_irq};
`endif
      default: obs = 'x;
    endcase
    n_checks++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("[TB] FAIL %s at edge %0d: observed=%h expected=%h", e.tag, edge_n, obs, e.val);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    sb_entry_t e;
    @(posedge clk);
    #1;
    edge_n++;
    while (sb_q.size() > 0 && sb_q[0].due <= edge_n) begin
      e = sb_q.pop_front();
      checkOutput(e);
    end
  endtask

  task automatic run_until(input int target);
    while (edge_n < target) step();
  endtask

  task automatic applyStimulus(input logic [NUM_PINS-1:0] raw, input logic byp);
    pins_raw = raw;
    bypass   = byp;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    last_rst = edge_n;
  endtask

  // First edge at or after 'from' on which the prescaler is at PRESCALE-1.
  function automatic int first_tick(input int from);
    int t;
    t = from;
    while (t <= last_rst || ((t - last_rst) % PRESCALE) != 0) t++;
    return t;
  endfunction

  // Edge at which a change driven just after edge e_d becomes visible.
  function automatic int accept_edge(input int e_d);
    return first_tick(e_d + 3) + PRESCALE * (DEBOUNCE_CNT - 1);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int a, e_d, e_b, t1, t2, t3;
`ifdef PIN_CHANGE_IRQ_EN
    int c;
    irq_clear = '0;
`endif
    rst       = 1'b1;
    raw_q     = '1;
    exp_banks = '0;
    applyStimulus(raw_q, 1'b0);

    // Reset held 3 cycles with all pins high
    push_check(3, 0, '0, "reset_state");
`ifdef PIN_CHANGE_IRQ_EN
    push_check(3, 2, '0, "reset_irq");
    push_check(3, 1, '0, "reset_mask");
`endif
    do_reset(3);
    a = accept_edge(last_rst);
    push_check(a - 1, 0, '0, "release_pre");
    push_check(a, 0, '1, "release_post");
    run_until(a + 1);

    // Clean edge on bank 1, bit 0
    raw_q = '0;
    applyStimulus(raw_q, 1'b0);
    push_check(edge_n + 1, 0, '0, "reset_clears_state");
    do_reset(1);
    run_until(edge_n + 2);
    e_d = edge_n;
    raw_q[8] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    a = accept_edge(e_d);
    push_check(a - 1, 0, exp_banks, "clean_pre");
    exp_banks[1] = 8'h01;
    push_check(a, 0, exp_banks, "clean_post");
    push_check(a + 5, 0, exp_banks, "clean_hold");
    run_until(a + 6);

    // Glitch on bank 0, bit 0: high for 2 ticks then low
    e_d = edge_n;
    raw_q[0] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    t1 = first_tick(e_d + 3);
    t2 = t1 + PRESCALE;
    t3 = t2 + PRESCALE;
    push_check(t2, 0, exp_banks, "glitch_t2");
    run_until(t2);
    raw_q[0] = 1'b0;
    applyStimulus(raw_q, 1'b0);
    push_check(t3, 0, exp_banks, "glitch_t3");
    push_check(t3 + 8, 0, exp_banks, "glitch_hold");
    run_until(t3 + 9);
    e_d = edge_n;
    raw_q[0] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    a = accept_edge(e_d);
    push_check(a - 1, 0, exp_banks, "after_glitch_pre");
    exp_banks[0] = 8'h01;
    push_check(a, 0, exp_banks, "after_glitch_post");
    run_until(a + 2);

    // Bypass: pin 127 follows the synchronizer
    e_d = edge_n;
    raw_q[127] = 1'b1;
    applyStimulus(raw_q, 1'b1);
    push_check(e_d + 2, 0, exp_banks, "bypass_pre");
    exp_banks[15] = 8'h80;
    push_check(e_d + 3, 0, exp_banks, "bypass_post");
    run_until(e_d + 4);
    e_b = edge_n;
    raw_q[127] = 1'b0;
    applyStimulus(raw_q, 1'b0);
    push_check(e_b + 6, 0, exp_banks, "pulse_hold_a");
    push_check(e_b + 12, 0, exp_banks, "pulse_hold_b");
    push_check(e_b + 24, 0, exp_banks, "pulse_hold_c");
    run_until(e_b + 4);
    raw_q[127] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    run_until(e_b + 25);

    // Reset in the middle of a count on pin 5
    e_d = edge_n;
    raw_q[5] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    t1 = first_tick(e_d + 3);
    t2 = t1 + PRESCALE;
    push_check(t2, 0, exp_banks, "midcount_pending");
    run_until(t2);
    push_check(t2 + 1, 0, '0, "midreset_clear");
    do_reset(1);
    a = accept_edge(last_rst);
    push_check(a - 1, 0, '0, "midreset_pre");
    exp_banks     = '0;
    exp_banks[0]  = 8'h21;
    exp_banks[1]  = 8'h01;
    exp_banks[15] = 8'h80;
    push_check(a, 0, exp_banks, "midreset_post");
    run_until(a + 2);

`ifdef PIN_CHANGE_IRQ_EN
    // Acknowledge the flags raised by the re-acceptance above
    c = edge_n;
    irq_clear = '1;
    step();
    irq_clear = '0;
    push_check(c + 2, 1, '0, "irq_all_cleared");
    push_check(c + 2, 2, '0, "irq_line_low");
    run_until(c + 3);

    // Accepted change on bank 3
    e_d = edge_n;
    raw_q[24] = 1'b1;
    applyStimulus(raw_q, 1'b0);
    a = accept_edge(e_d);
    push_check(a - 1, 1, '0, "irq_mask_pre");
    push_check(a, 1, 128'h0008, "irq_mask_set");
    push_check(a, 2, '0, "irq_line_delay");
    push_check(a + 1, 2, 128'h1, "irq_line_high");
    run_until(a + 2);

    // Lone clear of bank 3
    c = edge_n;
    push_check(c + 1, 1, '0, "irq_lone_clear");
    push_check(c + 1, 2, 128'h1, "irq_line_lag");
    push_check(c + 2, 2, '0, "irq_line_fall");
    irq_clear[3] = 1'b1;
    step();
    irq_clear = '0;
    run_until(c + 3);

    // Clear coinciding with a new bank-3 change
    e_d = edge_n;
    raw_q[24] = 1'b0;
    applyStimulus(raw_q, 1'b0);
    a = accept_edge(e_d);
    push_check(a - 1, 1, '0, "irq_coincide_pre");
    push_check(a, 1, 128'h0008, "irq_set_wins");
    push_check(a + 1, 2, 128'h1, "irq_coincide_line");
    run_until(a - 1);
    irq_clear[3] = 1'b1;
    step();
    irq_clear = '0;
    run_until(a + 2);
`endif

    while (sb_q.size() > 0) begin
      n_fail++;
      $display("[TB] FAIL unchecked_%s: observed=none expected_edge=%0d", sb_q[0].tag, sb_q[0].due);
      void'(sb_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
